// File: rtl/eddy_current_sensor_sequencer_pkg.sv
// Shared definitions for the eddy-current sensor conversion sequencer:
// FSM state codes, the default ADC result width and the recovery hold length.
package eddy_current_sensor_sequencer_pkg;

    // AD4011 result width
    localparam int DATA_W_DEF   = 18;

    // Cycles spent in RECOVER after the kick pulse, with events ignored
    localparam int RECOVER_HOLD = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

endpackage

// File: rtl/eddy_current_sensor_sequencer_decimator.sv
// Trigger qualification and decimation: turns PWM carrier pulses into
// conversion requests, firing on every (decim+1)-th event accepted in IDLE.
module ecs_trigger_decimator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_high_i,
    input  logic       trig_low_i,
    input  logic [1:0] trig_mask_i,
    input  logic       enable_i,
    input  logic [7:0] decim_i,
    input  logic       idle_i,
    output logic       fire_o,
    output logic       dropped_o
);

    logic       event_w;
    logic       wrap_w;
    logic [7:0] dec_cnt_q;
    logic [7:0] dec_cnt_d;

    // Qualify events and advance the decimation count only for events seen in IDLE.
    // ">=" rather than "==" so that lowering decim below the count fires on the next event.
    always_comb begin
        event_w   = enable_i & ((trig_high_i & trig_mask_i[0]) | (trig_low_i & trig_mask_i[1]));
        wrap_w    = (dec_cnt_q >= decim_i);
        fire_o    = event_w & idle_i & wrap_w;
        dropped_o = event_w & ~idle_i;
        dec_cnt_d = dec_cnt_q;
        if (event_w && idle_i) begin
            dec_cnt_d = wrap_w ? 8'd0 : dec_cnt_q + 8'd1;
        end
    end

    // Decimation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q <= 8'd0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
        end
    end

endmodule

// File: rtl/eddy_current_sensor_sequencer.sv
// Conversion sequencer for the AD4011 SPI master: issues one start pulse per
// selected PWM carrier event, guards each conversion with a watchdog, latches
// the X/Y results and keeps overrun / timeout / sample counters for software.
module eddy_current_sensor_sequencer
    import eddy_current_sensor_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TMO_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              trig_high,
    input  logic              trig_low,
    input  logic [1:0]        trig_mask,
    input  logic [7:0]        decim,
    input  logic [TMO_W-1:0]  timeout_cycles,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_data_x,
    input  logic [DATA_W-1:0] spi_data_y,
    output logic              spi_start,
    output logic [DATA_W-1:0] data_x,
    output logic [DATA_W-1:0] data_y,
    output logic              data_valid,
    output logic [CNT_W-1:0]  sample_count,
    output logic [7:0]        overrun_cnt,
    output logic [7:0]        timeout_cnt,
    output logic              busy
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic [1:0]        hold_q, hold_d;
    logic              spi_done_q;
    logic              spi_start_q, spi_start_d;
    logic [DATA_W-1:0] data_x_q, data_x_d;
    logic [DATA_W-1:0] data_y_q, data_y_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  sample_q, sample_d;
    logic [7:0]        ovr_q, ovr_d;
    logic [7:0]        tmo_q, tmo_d;

    logic fire;
    logic dropped;
    logic done_rise;
    logic tmo_hit;

    ecs_trigger_decimator u_decim (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_high_i (trig_high),
        .trig_low_i  (trig_low),
        .trig_mask_i (trig_mask),
        .enable_i    (enable),
        .decim_i     (decim),
        .idle_i      (state_q == ST_IDLE),
        .fire_o      (fire),
        .dropped_o   (dropped)
    );

    // Next-state, watchdog, result latching and counters.
    // spi_start is registered: it is set on the edge that enters START or RECOVER.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        hold_d      = hold_q;
        spi_start_d = 1'b0;
        data_x_d    = data_x_q;
        data_y_d    = data_y_q;
        valid_d     = 1'b0;
        sample_d    = sample_q;
        tmo_d       = tmo_q;
        // Events arriving during the RECOVER hold are ignored, not counted as overruns
        ovr_d       = (dropped && (state_q != ST_RECOVER)) ? sat_inc8(ovr_q) : ovr_q;
        done_rise   = spi_done & ~spi_done_q;
        tmo_hit     = (timeout_cycles != '0) && (wdog_q == timeout_cycles - TMO_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d     = ST_START;
                    spi_start_d = 1'b1;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wdog_d = wdog_q + TMO_W'(1);
                // A completion in the expiry cycle still counts as a good sample
                if (done_rise) begin
                    state_d  = ST_IDLE;
                    data_x_d = spi_data_x;
                    data_y_d = spi_data_y;
                    valid_d  = 1'b1;
                    sample_d = sample_q + CNT_W'(1);
                end else if (tmo_hit) begin
                    state_d     = ST_RECOVER;
                    tmo_d       = sat_inc8(tmo_q);
                    spi_start_d = 1'b1;
                    hold_d      = 2'd0;
                end
            end
            ST_RECOVER: begin
                // First cycle carries the kick pulse, then RECOVER_HOLD quiet cycles
                if (hold_q == 2'(RECOVER_HOLD)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, watchdog and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wdog_q      <= '0;
            hold_q      <= 2'd0;
            spi_done_q  <= 1'b0;
            spi_start_q <= 1'b0;
            data_x_q    <= '0;
            data_y_q    <= '0;
            valid_q     <= 1'b0;
            sample_q    <= '0;
            ovr_q       <= 8'd0;
            tmo_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            hold_q      <= hold_d;
            spi_done_q  <= spi_done;
            spi_start_q <= spi_start_d;
            data_x_q    <= data_x_d;
            data_y_q    <= data_y_d;
            valid_q     <= valid_d;
            sample_q    <= sample_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign spi_start    = spi_start_q;
    assign data_x       = data_x_q;
    assign data_y       = data_y_q;
    assign data_valid   = valid_q;
    assign sample_count = sample_q;
    assign overrun_cnt  = ovr_q;
    assign timeout_cnt  = tmo_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eddy_current_sensor_sequencer.sv
// Bench for the eddy-current sequencer: scenario table, hand-written timing
// sequences and a randomized run against a conversion-age reference model.
module tb_eddy_current_sensor_sequencer;

    localparam int DATA_W = 18;
    localparam int TMO_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              trig_high = 1'b0;
    logic              trig_low = 1'b0;
    logic [1:0]        trig_mask = 2'b00;
    logic [7:0]        decim = 8'd0;
    logic [TMO_W-1:0]  timeout_cycles = '0;
    logic              spi_done = 1'b0;
    logic [DATA_W-1:0] spi_data_x = '0;
    logic [DATA_W-1:0] spi_data_y = '0;
    logic              spi_start;
    logic [DATA_W-1:0] data_x;
    logic [DATA_W-1:0] data_y;
    logic              data_valid;
    logic [CNT_W-1:0]  sample_count;
    logic [7:0]        overrun_cnt;
    logic [7:0]        timeout_cnt;
    logic              busy;

    always #5 clk = ~clk;

    eddy_current_sensor_sequencer #(.DATA_W(DATA_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .trig_high      (trig_high),
        .trig_low       (trig_low),
        .trig_mask      (trig_mask),
        .decim          (decim),
        .timeout_cycles (timeout_cycles),
        .spi_done       (spi_done),
        .spi_data_x     (spi_data_x),
        .spi_data_y     (spi_data_y),
        .spi_start      (spi_start),
        .data_x         (data_x),
        .data_y         (data_y),
        .data_valid     (data_valid),
        .sample_count   (sample_count),
        .overrun_cnt    (overrun_cnt),
        .timeout_cnt    (timeout_cnt),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is described by its age in cycles since
    // the start pulse (-1 = none in flight); recovery by the quiet cycles left.
    int               m_age, m_rec, m_dec, m_samples, m_ovr, m_tmo;
    bit               m_prev_done, m_start, m_valid;
    logic [DATA_W-1:0] m_x, m_y;

    function automatic void model_reset();
        m_age = -1; m_rec = 0; m_dec = 0; m_samples = 0; m_ovr = 0; m_tmo = 0;
        m_prev_done = 0; m_start = 0; m_valid = 0; m_x = '0; m_y = '0;
    endfunction

    function automatic void model_step();
        bit ev, rise;
        ev = enable & ((trig_high & trig_mask[0]) | (trig_low & trig_mask[1]));
        rise = spi_done & !m_prev_done;
        m_prev_done = spi_done;
        m_start = 0;
        m_valid = 0;
        if (m_age < 0 && m_rec == 0) begin
            if (ev) begin
                if (m_dec >= int'(decim)) begin
                    m_dec = 0; m_age = 0; m_start = 1;
                end else begin
                    m_dec++;
                end
            end
        end else if (m_rec > 0) begin
            m_rec--;
        end else begin
            if (ev && m_ovr < 255) m_ovr++;
            if (m_age == 0) begin
                m_age = 1;
            end else if (rise) begin
                m_x = spi_data_x; m_y = spi_data_y; m_valid = 1;
                m_samples = (m_samples + 1) % 65536;
                m_age = -1;
            end else if (timeout_cycles != 0 && m_age == int'(timeout_cycles)) begin
                if (m_tmo < 255) m_tmo++;
                m_age = -1; m_rec = 3; m_start = 1;
            end else begin
                m_age++;
            end
        end
    endfunction

    // SPI master stand-in: any start pulse clears done and arms a completion
    // lat_cfg cycles later (-1 = never completes).
    int lat_cfg = 100;
    int mst_cnt = -1;
    bit fixed_data = 0;

    task automatic master_step();
        if (spi_start) begin
            spi_done = 1'b0;
            mst_cnt = lat_cfg;
        end else if (mst_cnt > 0) begin
            mst_cnt--;
            if (mst_cnt == 0) begin
                spi_done = 1'b1;
                spi_data_x = fixed_data ? 18'h2A5A5 : DATA_W'($urandom);
                spi_data_y = fixed_data ? 18'h15A5A : DATA_W'($urandom);
            end
        end
    endtask

    task automatic compare_all();
        chk("spi_start", spi_start, m_start);
        chk("data_valid", data_valid, m_valid);
        chk("busy", busy, (m_age >= 0 || m_rec > 0));
        chk("data_x", data_x, m_x);
        chk("data_y", data_y, m_y);
        chk("sample_count", sample_count, m_samples);
        chk("overrun_cnt", overrun_cnt, m_ovr);
        chk("timeout_cnt", timeout_cnt, m_tmo);
        if (spi_start === 1'b1) n_starts++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        compare_all();
        master_step();
        trig_high = 1'b0;
        trig_low  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        spi_done = 1'b0;
        mst_cnt = -1;
        trig_high = 1'b0;
        trig_low = 1'b0;
        #1;
        compare_all();
        chk("reset_busy_immediate", busy, 1'b0);
        chk("reset_start_immediate", spi_start, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         en;
        logic [7:0] dc;
        logic [1:0] mask;
        int         sel;      // 0 = trig_high, 1 = trig_low, 2 = both
        int         n_ev;
        int         gap;
        int         lat;
        int         tmo;
        int         e_starts;
        int         e_samples;
        int         e_tmo;
        int         e_ovr;
    } vec_t;

    vec_t vt[11];

    initial begin
        int s0, got;

        //          en dc    mask   sel n  gap  lat  tmo starts smp tmo ovr
        vt[0]  = '{1, 8'd0, 2'b01, 0, 1, 10,  100, 0,  1, 1, 0, 0};
        vt[1]  = '{1, 8'd3, 2'b11, 1, 8, 500, 100, 0,  2, 2, 0, 0};
        vt[2]  = '{1, 8'd1, 2'b11, 2, 2, 300, 100, 0,  1, 1, 0, 0};
        vt[3]  = '{1, 8'd0, 2'b10, 0, 3, 50,  20,  0,  0, 0, 0, 0};
        vt[4]  = '{0, 8'd0, 2'b11, 2, 3, 50,  20,  0,  0, 0, 0, 0};
        vt[5]  = '{1, 8'd0, 2'b01, 0, 1, 10,  -1,  50, 2, 0, 1, 0};
        vt[6]  = '{1, 8'd0, 2'b01, 0, 3, 20,  100, 0,  1, 1, 0, 2};
        vt[7]  = '{1, 8'd0, 2'b01, 0, 2, 60,  -1,  50, 4, 0, 2, 0};
        vt[8]  = '{1, 8'd0, 2'b01, 0, 1, 10,  50,  50, 1, 1, 0, 0};
        vt[9]  = '{1, 8'd0, 2'b01, 0, 1, 10,  51,  50, 2, 0, 1, 0};
        vt[10] = '{1, 8'd0, 2'b01, 0, 2, 53,  -1,  50, 2, 0, 1, 0};

        #2;
        do_reset();

        // Scenario table
        for (int i = 0; i < 11; i++) begin
            do_reset();
            enable = vt[i].en; decim = vt[i].dc; trig_mask = vt[i].mask;
            timeout_cycles = TMO_W'(vt[i].tmo); lat_cfg = vt[i].lat; fixed_data = 0;
            tick();
            s0 = n_starts;
            for (int e = 0; e < vt[i].n_ev; e++) begin
                trig_high = (vt[i].sel != 1);
                trig_low  = (vt[i].sel != 0);
                tick();
                repeat (vt[i].gap - 1) tick();
            end
            repeat (400) tick();
            chk($sformatf("vec%0d_starts", i), n_starts - s0, vt[i].e_starts);
            chk($sformatf("vec%0d_samples", i), sample_count, vt[i].e_samples);
            chk($sformatf("vec%0d_timeouts", i), timeout_cnt, vt[i].e_tmo);
            chk($sformatf("vec%0d_overruns", i), overrun_cnt, vt[i].e_ovr);
        end

        // Start timing and result latency with a fixed result word
        do_reset();
        enable = 1; decim = 0; trig_mask = 2'b01; timeout_cycles = '0;
        lat_cfg = 100; fixed_data = 1;
        tick();
        trig_high = 1;
        tick();
        chk("t1_start_next_cycle", spi_start, 1'b1);
        got = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (data_valid === 1'b1 && got < 0) got = k;
        end
        chk("t1_valid_latency", got, 101);
        chk("t1_data_x", data_x, 18'h2A5A5);
        chk("t1_data_y", data_y, 18'h15A5A);
        chk("t1_sample_count", sample_count, 1);

        // Overrun counting and saturation during a conversion that never ends
        do_reset();
        lat_cfg = -1; timeout_cycles = '0; fixed_data = 0;
        tick();
        s0 = n_starts;
        trig_high = 1;
        tick();
        repeat (20) tick();
        trig_high = 1;
        tick();
        chk("t4_overrun_one", overrun_cnt, 1);
        for (int k = 0; k < 299; k++) begin
            trig_high = 1;
            tick();
            tick();
        end
        chk("t4_overrun_saturated", overrun_cnt, 255);
        chk("t4_single_start", n_starts - s0, 1);
        chk("t4_still_busy", busy, 1'b1);

        // Asynchronous reset while busy, then a normal conversion
        do_reset();
        chk("t6_overrun_cleared", overrun_cnt, 0);
        lat_cfg = 100;
        tick();
        trig_high = 1;
        tick();
        chk("t6_start_after_reset", spi_start, 1'b1);
        repeat (150) tick();
        chk("t6_sample_count", sample_count, 1);

        // Randomized run against the model
        do_reset();
        fixed_data = 0;
        for (int c = 0; c < 20000; c++) begin
            if (c % 500 == 0) begin
                decim = 8'($urandom % 4);
                trig_mask = 2'($urandom);
                enable = ($urandom % 8) != 0;
                timeout_cycles = TMO_W'(20 + $urandom % 100);
                lat_cfg = ($urandom % 10 == 0) ? -1 : 1 + int'($urandom % 120);
            end
            trig_high = ($urandom % 40) == 0;
            trig_low  = ($urandom % 40) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
